debug_cmd_sequencer: RTL and testbench
======================================

# debug_cmd_sequencer

Host-side command controller for the external debugger: accepts abstract debug commands (halt, resume, step, register read/write, set breakpoint) and sequences the core's debug-support FSM through the halt-request / acknowledge handshake and the debug register port. It sits between the DMI/JTAG front end and the debug-support block, owns the level `dbg_halt_req_o`, and returns one response per accepted command with a cmderr code.

## Interface
- `TIMEOUT_CYCLES`, 1024, max cycles to wait for any core acknowledge (used only with `DBG_CMD_TIMEOUT_EN`)
- `REG_ADDR_W`, 16, register-port address width
- `clk_i` in 1: single clock
- `reset_i` in 1: asynchronous, active-high reset
- `cmd_valid_i` in 1 / `cmd_ready_o` out 1: command handshake
- `cmd_op_i` in 3: 0 NOP, 1 HALT, 2 RESUME, 3 STEP, 4 REG_READ, 5 REG_WRITE, 6 SET_BKPT, 7 reserved
- `cmd_addr_i` in REG_ADDR_W: register address (REG ops)
- `cmd_wdata_i` in 32: write data / breakpoint PC
- `rsp_valid_o` out 1: one-cycle response pulse
- `rsp_rdata_o` out 32: read data (REG_READ), else 0
- `rsp_err_o` out 3: 0 OK, 2 unsupported, 3 not halted, 4 timeout
- `halted_o` out 1: core confirmed halted
- `dbg_halt_req_o` out 1: level halt request to debug support
- `dbg_halt_ack_i`, `dbg_resume_ack_i`, `dbg_step_exec_i`, `dbg_reg_access_i` in 1: debug-support status
- `reg_req_o` out 1, `reg_we_o` out 1, `reg_addr_o` out REG_ADDR_W, `reg_wdata_o` out 32, `reg_ack_i` in 1, `reg_rdata_i` in 32: debug register port
- `bkpt_we_o` out 1, `bkpt_pc_o` out 32: dscratch0 breakpoint write

## Operation
- States: IDLE, HALT_WAIT, RESUME_WAIT, STEP_START, STEP_WAIT, REG_WAIT, RSP.
- `cmd_ready_o` = 1 only in IDLE; accept = `cmd_valid_i & cmd_ready_o`; op/addr/data latched on accept.
- HALT: halted → RSP OK. Else set `dbg_halt_req_o`, HALT_WAIT; on `dbg_halt_ack_i` set `halted_o`, RSP OK.
- RESUME: not halted → RSP OK. Else clear `dbg_halt_req_o`, RESUME_WAIT; on `dbg_resume_ack_i` clear `halted_o`, RSP OK.
- STEP (host pre-sets dcsr.step): not halted → RSP err 3. Else STEP_START until `dbg_step_exec_i`=1, then STEP_WAIT until `dbg_step_exec_i`=0 and `dbg_reg_access_i`=1 → RSP OK; `halt_req` stays 1 throughout.
- REG_READ/REG_WRITE: not halted → RSP err 3. Else REG_WAIT with `reg_req_o`=1 and stable addr/we/wdata until `reg_ack_i`; `reg_rdata_i` captured on ack.
- SET_BKPT: `bkpt_we_o` pulses one cycle with `bkpt_pc_o`=wdata, RSP OK; allowed in any halt state.
- NOP → RSP OK; op 7 → RSP err 2.
- RSP: `rsp_valid_o`=1 for one cycle, then IDLE.
- Ack arriving in the accept cycle is ignored; only acks in the wait state count.

## Timing
- Reset: all outputs 0, state IDLE, `halted_o`=0, `dbg_halt_req_o`=0. Reset mid-op aborts with no response.
- Immediate ops: `rsp_valid_o` cycle accept+1.
- Wait ops: request asserted cycle accept+1; response the cycle after the qualifying ack.
- `dbg_halt_req_o`, `halted_o` are registered; no combinational path from inputs to `cmd_ready_o`.
- `rsp_rdata_o`/`rsp_err_o` valid only with `rsp_valid_o`, else 0.

## Configuration
- `DBG_CMD_TIMEOUT_EN` defined: wait-state counter resets on entry, increments each cycle; reaching `TIMEOUT_CYCLES`-1 → RSP err 4. HALT timeout clears `dbg_halt_req_o`; REG timeout drops `reg_req_o`; `halted_o` unchanged.
- Undefined: no counter, wait states block indefinitely.

## Structure
- `debug_cmd_pkg`: op enum, cmderr enum, state enum, `DBG_CMD_DEFAULT_TIMEOUT`.
- One sub-module `dbg_ack_timeout` (counter, clear/enable, expired flag), instantiated only under the macro.

## Test plan
- HALT, ack 3 cycles after request → `dbg_halt_req_o`=1, `halted_o`=1, RSP err 0, latency 5 cycles.
- REG_READ addr 0x7B1 while running → RSP err 3, no `reg_req_o`; after halt, `reg_rdata_i`=0xDEADBEEF → `rsp_rdata_o`=0xDEADBEEF.
- STEP while halted: `step_exec` high 2 cycles then `reg_access` → RSP OK, `dbg_halt_req_o` never drops.
- RESUME → `dbg_halt_req_o`=0, on `resume_ack` `halted_o`=0, RSP OK; second RESUME → immediate OK.
- Timeout (macro, TIMEOUT_CYCLES=16): HALT with no ack → RSP err 4 after 16 cycles, `dbg_halt_req_o`=0.
- `reset_i` during REG_WAIT → `reg_req_o`, `halted_o`, `dbg_halt_req_o` 0 immediately, no `rsp_valid_o`.

Source files
------------

// File: rtl/debug_cmd_pkg.sv
// Shared types for the debug command sequencer: command opcodes, cmderr codes,
// sequencer states and the default acknowledge timeout.
package debug_cmd_pkg;

    localparam int DBG_CMD_DEFAULT_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_HALT      = 3'd1,
        OP_RESUME    = 3'd2,
        OP_STEP      = 3'd3,
        OP_REG_READ  = 3'd4,
        OP_REG_WRITE = 3'd5,
        OP_SET_BKPT  = 3'd6,
        OP_RSVD      = 3'd7
    } dbg_op_e;

    typedef enum logic [2:0] {
        ERR_OK          = 3'd0,
        ERR_UNSUPPORTED = 3'd2,
        ERR_NOT_HALTED  = 3'd3,
        ERR_TIMEOUT     = 3'd4
    } dbg_err_e;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_HALT_WAIT   = 3'd1,
        ST_RESUME_WAIT = 3'd2,
        ST_STEP_START  = 3'd3,
        ST_STEP_WAIT   = 3'd4,
        ST_REG_WAIT    = 3'd5,
        ST_RSP         = 3'd6
    } dbg_state_e;

endpackage

// File: rtl/dbg_ack_timeout.sv
// Wait-state cycle counter: cleared on entry to a wait state, counts while enabled,
// flags expiry at LIMIT-1. Only instantiated when DBG_CMD_TIMEOUT_EN is defined.
module dbg_ack_timeout
    import debug_cmd_pkg::*;
#(
    parameter int LIMIT = DBG_CMD_DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    assign expired_o = (count_q == CNT_W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/debug_cmd_sequencer.sv
// Debug command sequencer: turns host debug commands into the halt/resume/step
// handshake and register-port accesses. Optional ack timeout: DBG_CMD_TIMEOUT_EN.
module debug_cmd_sequencer
    import debug_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DBG_CMD_DEFAULT_TIMEOUT,
    parameter int REG_ADDR_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [2:0]            cmd_op_i,
    input  logic [REG_ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]           cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic [2:0]            rsp_err_o,
    output logic                  halted_o,
    output logic                  dbg_halt_req_o,
    input  logic                  dbg_halt_ack_i,
    input  logic                  dbg_resume_ack_i,
    input  logic                  dbg_step_exec_i,
    input  logic                  dbg_reg_access_i,
    output logic                  reg_req_o,
    output logic                  reg_we_o,
    output logic [REG_ADDR_W-1:0] reg_addr_o,
    output logic [31:0]           reg_wdata_o,
    input  logic                  reg_ack_i,
    input  logic [31:0]           reg_rdata_i,
    output logic                  bkpt_we_o,
    output logic [31:0]           bkpt_pc_o,
    output logic [2:0]            dbg_state_o
);

    // Handshake: a command is taken on any clock edge where cmd_valid_i and
    // cmd_ready_o are both high; exactly one rsp_valid_o pulse follows it.
    dbg_state_e            state_q, state_d;
    dbg_op_e               op_q, op_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  halted_q, halted_d;
    logic                  halt_req_q, halt_req_d;
    logic [2:0]            rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  bkpt_we_q, bkpt_we_d;
    logic                  cmd_accept;
    logic                  timeout_hit;

    assign cmd_ready_o    = (state_q == ST_IDLE);
    assign cmd_accept     = cmd_valid_i & cmd_ready_o;
    assign rsp_valid_o    = (state_q == ST_RSP);
    assign rsp_err_o      = rsp_valid_o ? rsp_err_q : 3'd0;
    assign rsp_rdata_o    = rsp_valid_o ? rsp_rdata_q : 32'd0;
    assign halted_o       = halted_q;
    assign dbg_halt_req_o = halt_req_q;
    assign reg_req_o      = (state_q == ST_REG_WAIT);
    assign reg_we_o       = reg_req_o & (op_q == OP_REG_WRITE);
    assign reg_addr_o     = reg_req_o ? addr_q : '0;
    assign reg_wdata_o    = reg_we_o ? wdata_q : 32'd0;
    assign bkpt_we_o      = bkpt_we_q;
    assign bkpt_pc_o      = bkpt_we_q ? wdata_q : 32'd0;
    assign dbg_state_o    = state_q;

`ifdef DBG_CMD_TIMEOUT_EN
    logic in_wait;
    assign in_wait = (state_q inside {ST_HALT_WAIT, ST_RESUME_WAIT, ST_STEP_START,
                                      ST_STEP_WAIT, ST_REG_WAIT});

    // Any state change restarts the count, so each wait state gets a full budget.
    dbg_ack_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_ack_timeout (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clr_i     (state_d != state_q),
        .en_i      (in_wait),
        .expired_o (timeout_hit)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        halted_d    = halted_q;
        halt_req_d  = halt_req_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        bkpt_we_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    op_d        = dbg_op_e'(cmd_op_i);
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_wdata_i;
                    rsp_err_d   = ERR_OK;
                    rsp_rdata_d = 32'd0;
                    state_d     = ST_RSP;
                    case (dbg_op_e'(cmd_op_i))
                        OP_NOP: ;
                        OP_HALT: begin
                            if (!halted_q) begin
                                halt_req_d = 1'b1;
                                state_d    = ST_HALT_WAIT;
                            end
                        end
                        OP_RESUME: begin
                            if (halted_q) begin
                                halt_req_d = 1'b0;
                                state_d    = ST_RESUME_WAIT;
                            end
                        end
                        OP_STEP: begin
                            if (halted_q) state_d = ST_STEP_START;
                            else          rsp_err_d = ERR_NOT_HALTED;
                        end
                        OP_REG_READ, OP_REG_WRITE: begin
                            if (halted_q) state_d = ST_REG_WAIT;
                            else          rsp_err_d = ERR_NOT_HALTED;
                        end
                        OP_SET_BKPT: bkpt_we_d = 1'b1;
                        default:     rsp_err_d = ERR_UNSUPPORTED;
                    endcase
                end
            end
            ST_HALT_WAIT: begin
                if (dbg_halt_ack_i) begin
                    halted_d = 1'b1;
                    state_d  = ST_RSP;
                end else if (timeout_hit) begin
                    halt_req_d = 1'b0;
                    rsp_err_d  = ERR_TIMEOUT;
                    state_d    = ST_RSP;
                end
            end
            ST_RESUME_WAIT: begin
                if (dbg_resume_ack_i) begin
                    halted_d = 1'b0;
                    state_d  = ST_RSP;
                end else if (timeout_hit) begin
                    rsp_err_d = ERR_TIMEOUT;
                    state_d   = ST_RSP;
                end
            end
            ST_STEP_START: begin
                if (dbg_step_exec_i) begin
                    state_d = ST_STEP_WAIT;
                end else if (timeout_hit) begin
                    rsp_err_d = ERR_TIMEOUT;
                    state_d   = ST_RSP;
                end
            end
            ST_STEP_WAIT: begin
                // The core is back in debug mode once the step finished and it polls registers.
                if (!dbg_step_exec_i && dbg_reg_access_i) begin
                    state_d = ST_RSP;
                end else if (timeout_hit) begin
                    rsp_err_d = ERR_TIMEOUT;
                    state_d   = ST_RSP;
                end
            end
            ST_REG_WAIT: begin
                if (reg_ack_i) begin
                    rsp_rdata_d = (op_q == OP_REG_READ) ? reg_rdata_i : 32'd0;
                    state_d     = ST_RSP;
                end else if (timeout_hit) begin
                    rsp_err_d = ERR_TIMEOUT;
                    state_d   = ST_RSP;
                end
            end
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            halted_q    <= 1'b0;
            halt_req_q  <= 1'b0;
            rsp_err_q   <= 3'd0;
            rsp_rdata_q <= '0;
            bkpt_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            halted_q    <= halted_d;
            halt_req_q  <= halt_req_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            bkpt_we_q   <= bkpt_we_d;
        end
    end

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Self-checking bench for debug_cmd_sequencer: scenario tasks drive commands and
// push expected responses; a negedge monitor pops and compares each response.
module tb_debug_cmd_sequencer;

`ifdef DBG_CMD_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_err;
    logic        halted;
    logic        halt_req;
    logic        halt_ack = 1'b0;
    logic        resume_ack = 1'b0;
    logic        step_exec = 1'b0;
    logic        reg_access = 1'b0;
    logic        reg_req;
    logic        reg_we;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack = 1'b0;
    logic [31:0] reg_rdata = '0;
    logic        bkpt_we;
    logic [31:0] bkpt_pc;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;
    int rsp_count = 0;
    logic [34:0] exp_q[$];

    debug_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .REG_ADDR_W(16)) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_op_i         (cmd_op),
        .cmd_addr_i       (cmd_addr),
        .cmd_wdata_i      (cmd_wdata),
        .rsp_valid_o      (rsp_valid),
        .rsp_rdata_o      (rsp_rdata),
        .rsp_err_o        (rsp_err),
        .halted_o         (halted),
        .dbg_halt_req_o   (halt_req),
        .dbg_halt_ack_i   (halt_ack),
        .dbg_resume_ack_i (resume_ack),
        .dbg_step_exec_i  (step_exec),
        .dbg_reg_access_i (reg_access),
        .reg_req_o        (reg_req),
        .reg_we_o         (reg_we),
        .reg_addr_o       (reg_addr),
        .reg_wdata_o      (reg_wdata),
        .reg_ack_i        (reg_ack),
        .reg_rdata_i      (reg_rdata),
        .bkpt_we_o        (bkpt_we),
        .bkpt_pc_o        (bkpt_pc),
        .dbg_state_o      (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [34:0] exp_v;
        if (!rst && rsp_valid) begin
            rsp_count++;
            rsp_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got err=%0d rdata=%h, no response expected",
                         rsp_err, rsp_rdata);
            end else begin
                exp_v = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== exp_v) begin
                    errors++;
                    $display("FAIL rsp_value: got err=%0d rdata=%h want err=%0d rdata=%h",
                             rsp_err, rsp_rdata, exp_v[34:32], exp_v[31:0]);
                end
            end
        end
    end

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic push,
                            input logic [2:0] e_err, input logic [31:0] e_rdata);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        if (push) exp_q.push_back({e_err, e_rdata});
        acc_cyc = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, halted, halt_req, reg_req, reg_we,
             reg_addr, reg_wdata, bkpt_we, bkpt_pc, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b err=%0d halted=%b req=%b reg_req=%b bkpt_we=%b state=%0d want all 0",
                     rsp_valid, rsp_err, halted, halt_req, reg_req, bkpt_we, dbg_state);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_immediate();
        send_cmd(3'd0, 16'h0, 32'h0, 1'b1, 3'd0, 32'h0);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL nop_ready_in_rsp: got %b want 0", cmd_ready);
        end
        tick();
        checks++;
        if (rsp_cyc - acc_cyc != 1) begin
            errors++;
            $display("FAIL nop_latency: got %0d want 1", rsp_cyc - acc_cyc);
        end
        send_cmd(3'd7, 16'h0, 32'h0, 1'b1, 3'd2, 32'h0);
        tick();
        checks++;
        if ({rsp_err, rsp_rdata} !== 35'd0) begin
            errors++;
            $display("FAIL rsp_idle_zero: got err=%0d rdata=%h want 0", rsp_err, rsp_rdata);
        end
        send_cmd(3'd6, 16'h0, 32'h1234_5678, 1'b1, 3'd0, 32'h0);
        checks++;
        if (bkpt_we !== 1'b1 || bkpt_pc !== 32'h1234_5678) begin
            errors++;
            $display("FAIL bkpt_pulse: got we=%b pc=%h want we=1 pc=12345678", bkpt_we, bkpt_pc);
        end
        tick();
        checks++;
        if (bkpt_we !== 1'b0 || bkpt_pc !== 32'h0) begin
            errors++;
            $display("FAIL bkpt_one_cycle: got we=%b pc=%h want we=0 pc=0", bkpt_we, bkpt_pc);
        end
        send_cmd(3'd2, 16'h0, 32'h0, 1'b1, 3'd0, 32'h0);
        tick();
        send_cmd(3'd3, 16'h0, 32'h0, 1'b1, 3'd3, 32'h0);
        tick();
        checks++;
        if (halt_req !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL running_status: got req=%b halted=%b want 0 0", halt_req, halted);
        end
    endtask

    task automatic test_reg_not_halted();
        logic seen_req = 1'b0;
        send_cmd(3'd4, 16'h07B1, 32'h0, 1'b1, 3'd3, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (reg_req !== 1'b0) seen_req = 1'b1;
            tick();
        end
        checks++;
        if (seen_req !== 1'b0) begin
            errors++;
            $display("FAIL reg_req_while_running: got 1 want 0");
        end
    endtask

    task automatic test_halt();
        halt_ack = 1'b1;
        send_cmd(3'd1, 16'h0, 32'h0, 1'b1, 3'd0, 32'h0);
        halt_ack = 1'b0;
        checks++;
        if (halt_req !== 1'b1 || halted !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_request: got req=%b halted=%b rsp=%b want 1 0 0",
                     halt_req, halted, rsp_valid);
        end
        tick();
        tick();
        tick();
        halt_ack = 1'b1;
        tick();
        halt_ack = 1'b0;
        checks++;
        if (halt_req !== 1'b1 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_confirmed: got req=%b halted=%b want 1 1", halt_req, halted);
        end
        tick();
        checks++;
        if (rsp_cyc - acc_cyc != 5) begin
            errors++;
            $display("FAIL halt_latency: got %0d want 5", rsp_cyc - acc_cyc);
        end
    endtask

    task automatic test_reg_read();
        send_cmd(3'd4, 16'h07B1, 32'h0, 1'b1, 3'd0, 32'hDEAD_BEEF);
        tick();
        tick();
        checks++;
        if (reg_req !== 1'b1 || reg_we !== 1'b0 || reg_addr !== 16'h07B1) begin
            errors++;
            $display("FAIL reg_read_req: got req=%b we=%b addr=%h want 1 0 07b1",
                     reg_req, reg_we, reg_addr);
        end
        reg_ack   = 1'b1;
        reg_rdata = 32'hDEAD_BEEF;
        tick();
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        checks++;
        if (reg_req !== 1'b0) begin
            errors++;
            $display("FAIL reg_req_drop: got %b want 0", reg_req);
        end
        tick();
    endtask

    task automatic test_reg_write();
        send_cmd(3'd5, 16'h07B2, 32'hCAFE_F00D, 1'b1, 3'd0, 32'h0);
        checks++;
        if (reg_req !== 1'b1 || reg_we !== 1'b1 || reg_addr !== 16'h07B2 ||
            reg_wdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL reg_write_req: got req=%b we=%b addr=%h wdata=%h want 1 1 07b2 cafef00d",
                     reg_req, reg_we, reg_addr, reg_wdata);
        end
        reg_ack   = 1'b1;
        reg_rdata = 32'h1111_1111;
        tick();
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        tick();
        checks++;
        if (rsp_cyc - acc_cyc != 2) begin
            errors++;
            $display("FAIL reg_write_latency: got %0d want 2", rsp_cyc - acc_cyc);
        end
    endtask

    task automatic test_step();
        logic req_dropped = 1'b0;
        int base;
        base = rsp_count;
        send_cmd(3'd3, 16'h0, 32'h0, 1'b1, 3'd0, 32'h0);
        step_exec = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (halt_req !== 1'b1) req_dropped = 1'b1;
            tick();
        end
        step_exec = 1'b0;
        if (halt_req !== 1'b1) req_dropped = 1'b1;
        tick();
        checks++;
        if (rsp_count != base) begin
            errors++;
            $display("FAIL step_early_rsp: got %0d responses want %0d", rsp_count, base);
        end
        reg_access = 1'b1;
        if (halt_req !== 1'b1) req_dropped = 1'b1;
        tick();
        reg_access = 1'b0;
        if (halt_req !== 1'b1) req_dropped = 1'b1;
        tick();
        checks++;
        if (req_dropped !== 1'b0 || rsp_cyc - acc_cyc != 5) begin
            errors++;
            $display("FAIL step_sequence: got req_dropped=%b latency=%0d want 0 5",
                     req_dropped, rsp_cyc - acc_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op;
        logic [2:0]  e_err;
        logic [31:0] pc;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       op = 3'd0;
                1:       op = 3'd1;
                2:       op = 3'd6;
                default: op = 3'd7;
            endcase
            pc    = $urandom;
            e_err = (op == 3'd7) ? 3'd2 : 3'd0;
            send_cmd(op, 16'h0, pc, 1'b1, e_err, 32'h0);
            if (op == 3'd6) begin
                checks++;
                if (bkpt_we !== 1'b1 || bkpt_pc !== pc) begin
                    errors++;
                    $display("FAIL b2b_bkpt: got we=%b pc=%h want 1 %h", bkpt_we, bkpt_pc, pc);
                end
            end
            tick();
        end
    endtask

    task automatic test_resume();
        send_cmd(3'd2, 16'h0, 32'h0, 1'b1, 3'd0, 32'h0);
        checks++;
        if (halt_req !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL resume_request: got req=%b halted=%b want 0 1", halt_req, halted);
        end
        tick();
        resume_ack = 1'b1;
        tick();
        resume_ack = 1'b0;
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL resume_halted: got %b want 0", halted);
        end
        tick();
        send_cmd(3'd2, 16'h0, 32'h0, 1'b1, 3'd0, 32'h0);
        tick();
        checks++;
        if (rsp_cyc - acc_cyc != 1) begin
            errors++;
            $display("FAIL resume_second_latency: got %0d want 1", rsp_cyc - acc_cyc);
        end
    endtask

    task automatic halt_with_ack();
        send_cmd(3'd1, 16'h0, 32'h0, 1'b1, 3'd0, 32'h0);
        halt_ack = 1'b1;
        tick();
        halt_ack = 1'b0;
        tick();
    endtask

`ifdef DBG_CMD_TIMEOUT_EN
    task automatic test_timeout();
        send_cmd(3'd1, 16'h0, 32'h0, 1'b1, 3'd4, 32'h0);
        for (int i = 0; i < TMO + 2; i++) tick();
        checks++;
        if (rsp_cyc - acc_cyc != TMO + 1 || halt_req !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_timeout: got latency=%0d req=%b halted=%b want %0d 0 0",
                     rsp_cyc - acc_cyc, halt_req, halted, TMO + 1);
        end
        halt_with_ack();
    endtask
`else
    task automatic test_timeout();
        int base;
        base = rsp_count;
        send_cmd(3'd1, 16'h0, 32'h0, 1'b1, 3'd0, 32'h0);
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (rsp_count != base || halt_req !== 1'b1) begin
            errors++;
            $display("FAIL halt_blocks: got responses=%0d req=%b want %0d 1",
                     rsp_count, halt_req, base);
        end
        halt_ack = 1'b1;
        tick();
        halt_ack = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid_op();
        int base;
        send_cmd(3'd4, 16'h0300, 32'h0, 1'b0, 3'd0, 32'h0);
        tick();
        base = rsp_count;
        rst = 1'b1;
        #1;
        checks++;
        if (reg_req !== 1'b0 || halted !== 1'b0 || halt_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got reg_req=%b halted=%b req=%b want 0 0 0",
                     reg_req, halted, halt_req);
        end
        reg_ack = 1'b1;
        tick();
        tick();
        reg_ack = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (rsp_count != base) begin
            errors++;
            $display("FAIL reset_no_rsp: got %0d responses want %0d", rsp_count, base);
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_reg_not_halted();
        test_halt();
        test_reg_read();
        test_reg_write();
        test_step();
        test_back_to_back();
        test_resume();
        test_timeout();
        test_reset_mid_op();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
